bit_pixel_column_writer: RTL and testbench
==========================================

// Module: bit_pixel_column_writer
// PURPOSE
// - Parametrised successor of the bit-pixel BRAM rotator: buffers NUM_PIX-wide bit-pixel words plus sideband in a
//   show-ahead FIFO, writes them column-major into a NUM_BUFS x NUM_THIRDS banked BRAM, honours BRAM-port backpressure.
// - Sits between the census/bit-pixel stage and the block-matcher BRAM. Tracks SOF, resyncs on framing errors,
//   flags overflow and advances image_number each completed image.
// PARAMETERS
// - THIRD_COLS   240  pixel columns per third (multiple of NUM_PIX)
// - THIRD_ROWS   480  rows per third
// - NUM_PIX      16   pixels per input word / BRAM word
// - NUM_THIRDS   3    thirds per image (2..4)
// - NUM_BUFS     2    image buffers, round-robin (power of 2, >=2)
// - FIFO_DEPTH   512  input FIFO words (power of 2)
// - AFULL_LEVEL  448  fill level at/above which fifo_almost_full asserts
// PORTS
// - clk              in   1   clock
// - reset            in   1   synchronous, active-high
// - bit_pix          in   NUM_PIX+8  {cam[3:0], third[1:0], sof, eof, pixels[NUM_PIX-1:0]}
// - bit_pix_valid    in   1   write strobe into FIFO
// - fifo_almost_full out  1   level >= AFULL_LEVEL
// - pix_out          out  NUM_PIX  BRAM write data
// - pix_out_wren     out  1   BRAM write strobe
// - pix_out_ready    in   1   BRAM port granted this cycle
// - pix_out_addr     out  BUF_W+2+ADDR_W  {buf_idx, third, word_addr}
// - image_number     out  4   completed images, mod 16
// - frame_err        out  1   one-cycle pulse on SOF mid-third or third-index mismatch
// - overflow         out  1   sticky: word arrived while FIFO full (cleared only by reset)
// BEHAVIOUR
// - WR_COLS=THIRD_COLS/NUM_PIX; ADDR_W=$clog2(WR_COLS*THIRD_ROWS); BUF_W=max(1,$clog2(NUM_BUFS)).
// - Reset: FIFO cleared, state ST_SYNC, row=col=addr=0, buf_idx=0, exp_third=0, image_number=0, overflow=0;
//   pix_out_wren=0, frame_err=0 combinationally from state.
// - Pop condition: ~empty & pix_out_ready (ST_RUN) or ~empty (ST_SYNC). Write is same-cycle as pop; wren=pop in ST_RUN.
// - ST_SYNC: discard head words until head has sof=1 and third==exp_third -> ST_RUN, that word written at addr 0 (no pop before check).
// - ST_RUN addressing: word_addr = row*WR_COLS + col; row increments first (addr += WR_COLS);
//   row==THIRD_ROWS-1 -> row=0, col+1, addr=col+1; last word (row max, col max) -> addr=0, col=0,
//   exp_third+1; if third==NUM_THIRDS-1: exp_third=0, buf_idx+1 (wrap NUM_BUFS), image_number+1.
// - Head sof=1 with (row,col)!=(0,0), or third!=exp_third at (0,0): no write, frame_err pulse, counters cleared,
//   exp_third=0, -> ST_SYNC (word not popped; re-evaluated next cycle in ST_SYNC).
// - eof informational only; not checked.
// - pix_out_ready=0: nothing pops, counters hold; wren stays low; address/data stable.
// - Simultaneous push and pop: level unchanged. Push when full and no pop: word dropped, overflow=1.
// - Push with pop while full: accepted (pop frees the slot the same cycle).
// CONFIGURATION
// - BPCW_TEST_PATTERN_EN defined: pix_out = {buf_idx, third, word_addr} zero-extended/truncated to NUM_PIX LSBs;
//   addressing/handshake unchanged. Undefined: pix_out = FIFO pixel field.
// STRUCTURE
// - Package bit_pix_pkg: statetype {ST_SYNC, ST_RUN}, sideband bit offsets (SB_EOF, SB_SOF, SB_THIRD_LO, SB_CAM_LO),
//   SB_WIDTH=8.
// - Sub-module bit_pix_sa_fifo: parametrised single-clock show-ahead FIFO with level, empty, full, sclr.
// - Top holds FSM, address counters, buffer/image counters, error/overflow logic.
// TESTING (THIRD_COLS=32, THIRD_ROWS=4, NUM_PIX=16, NUM_THIRDS=3, NUM_BUFS=2: 8 words/third)
// - 8 words third0, sof on first, ready=1 -> addrs 0,2,4,6,1,3,5,7; addr MSBs {buf0,third0}.
// - 3 thirds x 8 words -> image_number 0->1, buf_idx 0->1 after 24th write; next image writes {1,third,..}.
// - Toggle pix_out_ready 0/1 every cycle -> same address sequence, no lost/duplicated words, wren only when ready.
// - Garbage 3 words (sof=0) then valid third -> 3 words discarded, first write addr 0, no frame_err.
// - sof on 5th word of a third -> frame_err 1 cycle, that word rewritten at addr 0 via ST_SYNC, no image increment.
// - 513 pushes, ready=0 -> overflow=1 sticky, fifo_almost_full=1 at level 448; reset mid-third -> all outputs reset values.

Source files
------------

// File: rtl/bit_pixel_column_writer_pkg.sv
// -----------------------------------------------------------------------------
// bit_pix_pkg
// Shared types and constants for the bit-pixel column writer.
//   statetype        : writer FSM states (ST_SYNC hunts for a frame start,
//                      ST_RUN writes words column-major)
//   SB_*             : bit offsets inside the 8-bit sideband that sits above the
//                      pixel field of every input word
//                      ({cam[3:0], third[1:0], sof, eof})
//   clog2_min1       : $clog2 that never returns 0, for counter/index widths
// -----------------------------------------------------------------------------
package bit_pix_pkg;

   typedef enum logic [0:0] {
      ST_SYNC = 1'b0,
      ST_RUN  = 1'b1
   } statetype;

   localparam int SB_WIDTH    = 8;
   localparam int SB_EOF      = 0;
   localparam int SB_SOF      = 1;
   localparam int SB_THIRD_LO = 2;
   localparam int SB_CAM_LO   = 4;

   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/bit_pixel_column_writer_fifo.sv
// -----------------------------------------------------------------------------
// bit_pix_sa_fifo
// Single-clock show-ahead FIFO: the head word is visible on rd_data whenever
// empty is low, and rd_en consumes it on the next clock edge.
//   clk      in   clock
//   sclr     in   synchronous clear (pointers and level), active-high
//   wr_en    in   push request; accepted when not full, or when full but a pop
//                 happens in the same cycle
//   wr_data  in   WIDTH-bit word to push
//   rd_en    in   pop request (ignored while empty)
//   rd_data  out  head word
//   level    out  number of stored words (0..DEPTH)
//   empty    out  level == 0
//   full     out  level == DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module bit_pix_sa_fifo #(
   parameter  int WIDTH = 24,
   parameter  int DEPTH = 512,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [LVL_W-1:0] level,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic             push;
   logic             pop;

   assign empty = (level_reg == '0);
   assign full  = (level_reg == LVL_W'(DEPTH));
   assign pop   = rd_en & ~empty;
   // A pop frees the slot on the same edge, so a full FIFO can still accept.
   assign push  = wr_en & (~full | pop);

   // Show-ahead: head is read straight from the array.
   assign rd_data = mem[rd_ptr_reg];
   assign level   = level_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/bit_pixel_column_writer.sv
// -----------------------------------------------------------------------------
// bit_pixel_column_writer
// Buffers bit-pixel words (pixels plus sideband) in a show-ahead FIFO and writes
// them column-major into a NUM_BUFS x NUM_THIRDS banked BRAM, one word per
// granted BRAM cycle. Hunts for a start-of-frame after reset or a framing
// error, counts completed images and flags FIFO overflow.
//   clk              in   clock
//   reset            in   synchronous, active-high
//   bit_pix          in   {cam[3:0], third[1:0], sof, eof, pixels[NUM_PIX-1:0]}
//   bit_pix_valid    in   push strobe into the FIFO
//   fifo_almost_full out  FIFO level >= AFULL_LEVEL
//   pix_out          out  BRAM write data
//   pix_out_wren     out  BRAM write strobe (only while pix_out_ready)
//   pix_out_ready    in   BRAM port granted this cycle
//   pix_out_addr     out  {buf_idx, third, word_addr}
//   image_number     out  completed images, mod 16
//   frame_err        out  one-cycle pulse on SOF mid-third or wrong third index
//   overflow         out  sticky: a word arrived while the FIFO was full
// Build option: BPCW_TEST_PATTERN_EN replaces the pixel data with the write
// address (zero-extended/truncated to NUM_PIX bits) to check BRAM wiring.
// -----------------------------------------------------------------------------
module bit_pixel_column_writer
   import bit_pix_pkg::*;
#(
   parameter  int THIRD_COLS  = 240,
   parameter  int THIRD_ROWS  = 480,
   parameter  int NUM_PIX     = 16,
   parameter  int NUM_THIRDS  = 3,
   parameter  int NUM_BUFS    = 2,
   parameter  int FIFO_DEPTH  = 512,
   parameter  int AFULL_LEVEL = 448,
   localparam int WR_COLS     = THIRD_COLS / NUM_PIX,
   localparam int ADDR_W      = clog2_min1(WR_COLS * THIRD_ROWS),
   localparam int BUF_W       = clog2_min1(NUM_BUFS),
   localparam int OUT_ADDR_W  = BUF_W + 2 + ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_PIX+7:0]    bit_pix,
   input  logic                  bit_pix_valid,
   output logic                  fifo_almost_full,
   output logic [NUM_PIX-1:0]    pix_out,
   output logic                  pix_out_wren,
   input  logic                  pix_out_ready,
   output logic [OUT_ADDR_W-1:0] pix_out_addr,
   output logic [3:0]            image_number,
   output logic                  frame_err,
   output logic                  overflow
);

   localparam int IN_W  = NUM_PIX + SB_WIDTH;
   localparam int ROW_W = clog2_min1(THIRD_ROWS);
   localparam int COL_W = clog2_min1(WR_COLS);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   // FIFO interface
   logic [IN_W-1:0]  head;
   logic [LVL_W-1:0] fifo_level;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;

   // Head decode
   logic [NUM_PIX-1:0] head_pix;
   logic               head_sof;
   logic [1:0]         head_third;
   logic               sb_unused;

   // State
   statetype          state_reg,     state_next;
   logic [ROW_W-1:0]  row_reg,       row_next;
   logic [COL_W-1:0]  col_reg,       col_next;
   logic [ADDR_W-1:0] addr_reg,      addr_next;
   logic [1:0]        exp_third_reg, exp_third_next;
   logic [BUF_W-1:0]  buf_idx_reg,   buf_idx_next;
   logic [3:0]        image_reg,     image_next;
   logic              overflow_reg;
   logic              wren_c;
   logic              frame_err_c;
   logic              at_origin;

   bit_pix_sa_fifo #(
      .WIDTH (IN_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .sclr    (reset),
      .wr_en   (bit_pix_valid),
      .wr_data (bit_pix),
      .rd_en   (pop),
      .rd_data (head),
      .level   (fifo_level),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign head_pix   = head[NUM_PIX-1:0];
   assign head_sof   = head[NUM_PIX + SB_SOF];
   assign head_third = head[NUM_PIX + SB_THIRD_LO +: 2];
   // eof and camera id travel with the word but do not steer the writer.
   assign sb_unused  = ^{head[NUM_PIX + SB_EOF], head[NUM_PIX + SB_CAM_LO +: 4]};

   assign at_origin = (row_reg == '0) && (col_reg == '0);

   always_comb begin
      state_next     = state_reg;
      row_next       = row_reg;
      col_next       = col_reg;
      addr_next      = addr_reg;
      exp_third_next = exp_third_reg;
      buf_idx_next   = buf_idx_reg;
      image_next     = image_reg;
      pop            = 1'b0;
      wren_c         = 1'b0;
      frame_err_c    = 1'b0;

      case (state_reg)
         ST_SYNC: begin
            // The matching word stays in the FIFO; ST_RUN writes it at (0,0).
            if (!fifo_empty) begin
               if (head_sof && (head_third == exp_third_reg)) begin
                  state_next = ST_RUN;
               end else begin
                  pop = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (!fifo_empty) begin
               if ((head_sof && !at_origin) ||
                   (at_origin && (head_third != exp_third_reg))) begin
                  // Leave the offending word at the head so ST_SYNC can
                  // restart the third from it.
                  frame_err_c    = 1'b1;
                  row_next       = '0;
                  col_next       = '0;
                  addr_next      = '0;
                  exp_third_next = '0;
                  state_next     = ST_SYNC;
               end else if (pix_out_ready) begin
                  pop    = 1'b1;
                  wren_c = 1'b1;
                  // Column-major walk: rows first, then step to the next column.
                  if (row_reg == ROW_W'(THIRD_ROWS - 1)) begin
                     row_next = '0;
                     if (col_reg == COL_W'(WR_COLS - 1)) begin
                        col_next  = '0;
                        addr_next = '0;
                        if (exp_third_reg == 2'(NUM_THIRDS - 1)) begin
                           exp_third_next = '0;
                           buf_idx_next   = (buf_idx_reg == BUF_W'(NUM_BUFS - 1)) ?
                                            '0 : buf_idx_reg + 1'b1;
                           image_next     = image_reg + 4'd1;
                        end else begin
                           exp_third_next = exp_third_reg + 2'd1;
                        end
                     end else begin
                        col_next  = col_reg + 1'b1;
                        addr_next = ADDR_W'(col_reg) + 1'b1;
                     end
                  end else begin
                     row_next  = row_reg + 1'b1;
                     addr_next = addr_reg + ADDR_W'(WR_COLS);
                  end
               end
            end
         end

         default: begin
            state_next = ST_SYNC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_SYNC;
         row_reg       <= '0;
         col_reg       <= '0;
         addr_reg      <= '0;
         exp_third_reg <= '0;
         buf_idx_reg   <= '0;
         image_reg     <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         row_reg       <= row_next;
         col_reg       <= col_next;
         addr_reg      <= addr_next;
         exp_third_reg <= exp_third_next;
         buf_idx_reg   <= buf_idx_next;
         image_reg     <= image_next;
         // Only a push that the FIFO cannot absorb (full, no pop) is lost.
         if (bit_pix_valid && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign pix_out_addr     = {buf_idx_reg, exp_third_reg, addr_reg};
   assign pix_out_wren     = wren_c;
   assign frame_err        = frame_err_c;
   assign image_number     = image_reg;
   assign overflow         = overflow_reg;
   assign fifo_almost_full = (fifo_level >= LVL_W'(AFULL_LEVEL));

`ifdef BPCW_TEST_PATTERN_EN
   logic [NUM_PIX+OUT_ADDR_W-1:0] tp_unused_ext;
   logic                          pix_unused;

   assign tp_unused_ext = {{NUM_PIX{1'b0}}, pix_out_addr};
   assign pix_out       = tp_unused_ext[NUM_PIX-1:0];
   assign pix_unused    = ^head_pix;
`else
   assign pix_out = head_pix;
`endif

endmodule

// File: tb/tb_bit_pixel_column_writer.sv
// -----------------------------------------------------------------------------
// tb_bit_pixel_column_writer
// Directed bench for bit_pixel_column_writer with a small geometry
// (32x4 pixels per third, 16 pixels per word -> 8 words per third).
// Word order inside a third is column-major: addresses 0,2,4,6,1,3,5,7.
// Full address = {buf(1), third(2), word(3)} = buf*32 + third*8 + word.
// -----------------------------------------------------------------------------
module tb_bit_pixel_column_writer;

   localparam int THIRD_COLS = 32;
   localparam int THIRD_ROWS = 4;
   localparam int NUM_PIX    = 16;

   logic        clk;
   logic        reset;
   logic [23:0] bit_pix;
   logic        bit_pix_valid;
   logic        fifo_almost_full;
   logic [15:0] pix_out;
   logic        pix_out_wren;
   logic        pix_out_ready;
   logic [5:0]  pix_out_addr;
   logic [3:0]  image_number;
   logic        frame_err;
   logic        overflow;

   int check_count = 0;
   int error_count = 0;

   // Write log kept by the monitor (single writer); phases read from a base index.
   logic [5:0]  wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   int          bad_wren   = 0;
   int          ferr_count = 0;

   // 0: ready low, 1: ready high, 2: toggle every cycle
   int ready_mode = 0;

   bit_pixel_column_writer #(
      .THIRD_COLS  (THIRD_COLS),
      .THIRD_ROWS  (THIRD_ROWS),
      .NUM_PIX     (NUM_PIX),
      .NUM_THIRDS  (3),
      .NUM_BUFS    (2),
      .FIFO_DEPTH  (512),
      .AFULL_LEVEL (448)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .bit_pix          (bit_pix),
      .bit_pix_valid    (bit_pix_valid),
      .fifo_almost_full (fifo_almost_full),
      .pix_out          (pix_out),
      .pix_out_wren     (pix_out_wren),
      .pix_out_ready    (pix_out_ready),
      .pix_out_addr     (pix_out_addr),
      .image_number     (image_number),
      .frame_err        (frame_err),
      .overflow         (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      pix_out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       pix_out_ready = 1'b0;
            1:       pix_out_ready = 1'b1;
            default: pix_out_ready = ~pix_out_ready;
         endcase
      end
   end

   always @(negedge clk) begin
      if (pix_out_wren) begin
         wr_addr_q.push_back(pix_out_addr);
         wr_data_q.push_back(pix_out);
         $display("write addr=%02h data=%04h ready=%0b", pix_out_addr, pix_out, pix_out_ready);
         if (!pix_out_ready) bad_wren++;
      end
      if (frame_err) ferr_count++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got stuck, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input int observed, input int expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, observed, observed, expected, expected);
      end
   endtask

   task automatic push_word(input int third, input bit sof, input bit eof, input int pix);
      bit_pix       = {4'h0, 2'(third), sof, eof, 16'(pix)};
      bit_pix_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_pix_valid = 1'b0;
   endtask

   task automatic wait_writes(input int target);
      int cycles = 0;
      while ((wr_addr_q.size() < target) && (cycles < 400)) begin
         @(posedge clk);
         cycles++;
      end
      @(posedge clk);
      #1;
      check_value("write_count", wr_addr_q.size(), target);
   endtask

   function automatic int word_addr(input int n);
      return (n % THIRD_ROWS) * 2 + (n / THIRD_ROWS);
   endfunction

   function automatic int exp_data(input int addr, input int pix);
`ifdef BPCW_TEST_PATTERN_EN
      return addr;
`else
      return pix;
`endif
   endfunction

   task automatic check_write(input int idx, input int addr, input int pix);
      int got_addr;
      int got_data;
      got_addr = (idx < wr_addr_q.size()) ? int'(wr_addr_q[idx]) : -1;
      got_data = (idx < wr_data_q.size()) ? int'(wr_data_q[idx]) : -1;
      check_value($sformatf("addr[%0d]", idx), got_addr, addr);
      check_value($sformatf("data[%0d]", idx), got_data, exp_data(addr, pix));
   endtask

   // Push one complete third (sof on first, eof on last) and check its 8 writes.
   task automatic do_third(input int bufn, input int third, input int pixbase);
      int base;
      base = wr_addr_q.size();
      for (int i = 0; i < 8; i++) begin
         push_word(third, (i == 0), (i == 7), pixbase + i);
      end
      wait_writes(base + 8);
      for (int i = 0; i < 8; i++) begin
         check_write(base + i, bufn * 32 + third * 8 + word_addr(i), pixbase + i);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_wren"}, pix_out_wren, 0);
      check_value({tag, "_frame_err"}, frame_err, 0);
      check_value({tag, "_image_number"}, image_number, 0);
      check_value({tag, "_overflow"}, overflow, 0);
      check_value({tag, "_almost_full"}, fifo_almost_full, 0);
      check_value({tag, "_addr"}, pix_out_addr, 0);
   endtask

   initial begin
      int base;
      int ferr0;

      reset         = 1'b1;
      bit_pix       = '0;
      bit_pix_valid = 1'b0;
      ready_mode    = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;

      // Garbage without sof is discarded in ST_SYNC, then a clean third 0.
      ready_mode = 1;
      @(posedge clk);
      #1;
      base  = wr_addr_q.size();
      ferr0 = ferr_count;
      for (int i = 0; i < 3; i++) push_word(0, 1'b0, 1'b0, 16'hBAD0 + i);
      do_third(0, 0, 16'h1000);
      repeat (10) @(posedge clk);
      #1;
      check_value("garbage_discarded", wr_addr_q.size() - base, 8);
      check_value("garbage_no_frame_err", ferr_count - ferr0, 0);
      check_value("image_after_third0", image_number, 0);

      do_third(0, 1, 16'h1100);
      do_third(0, 2, 16'h1200);
      check_value("image_after_img0", image_number, 1);

      // Backpressure: ready toggles every cycle.
      ready_mode = 2;
      do_third(1, 0, 16'h2000);
      check_value("wren_only_when_ready", bad_wren, 0);
      ready_mode = 1;
      do_third(1, 1, 16'h2100);
      do_third(1, 2, 16'h2200);
      check_value("image_after_img1", image_number, 2);

      // sof on the 5th word of a third: one frame_err, restart at addr 0.
      base  = wr_addr_q.size();
      ferr0 = ferr_count;
      for (int i = 0; i < 12; i++) begin
         push_word(0, (i == 0) || (i == 4), (i == 11), 16'h3000 + i);
      end
      wait_writes(base + 12);
      for (int i = 0; i < 4; i++) check_write(base + i, word_addr(i), 16'h3000 + i);
      for (int j = 0; j < 8; j++) check_write(base + 4 + j, word_addr(j), 16'h3004 + j);
      check_value("mid_sof_frame_err_pulses", ferr_count - ferr0, 1);
      check_value("mid_sof_image_hold", image_number, 2);

      // Overflow: ready low, 513 pushes into the 512-deep FIFO (third 1 matches).
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      base = wr_addr_q.size();
      for (int i = 1; i <= 513; i++) begin
         bit_pix       = {4'h0, 2'd1, 1'b0, 1'b0, 16'(16'h5000 + i)};
         bit_pix_valid = 1'b1;
         @(posedge clk);
         #1;
         if (i == 447) check_value("afull_at_447", fifo_almost_full, 0);
         if (i == 448) check_value("afull_at_448", fifo_almost_full, 1);
         if (i == 512) check_value("overflow_at_512", overflow, 0);
         if (i == 513) check_value("overflow_at_513", overflow, 1);
      end
      bit_pix_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_value("overflow_sticky", overflow, 1);
      check_value("afull_held", fifo_almost_full, 1);
      check_value("no_write_without_ready", wr_addr_q.size() - base, 0);

      // Let a few words go out so the writer is mid-third, then reset.
      ready_mode = 1;
      repeat (4) @(posedge clk);
      #1;
      check_value("mid_third_writes_seen", (wr_addr_q.size() - base) > 0, 1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      do_third(0, 0, 16'h4000);
      check_value("image_after_reset_third", image_number, 0);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
